// File: rtl/countdown_mm_ss.sv
// BCD MM:SS countdown timer with alarm ring phase for the kitchen/nap timer mode.
// Optional macro COUNTDOWN_SNOOZE_EN adds a Snooze input that reloads SNOOZE_MIN:00 from RING.
module countdown_mm_ss #(
  parameter int BEEP_TICKS = 10
`ifdef COUNTDOWN_SNOOZE_EN
  , parameter int SNOOZE_MIN = 5
`endif
) (
  input  logic       Clk,
  input  logic       Clr,
  input  logic       Tick,
  input  logic       LD,
  input  logic [2:0] IN_MT,
  input  logic [3:0] IN_MU,
  input  logic [2:0] IN_ST,
  input  logic [3:0] IN_SU,
  input  logic       Start,
  input  logic       Stop,
`ifdef COUNTDOWN_SNOOZE_EN
  input  logic       Snooze,
`endif
  output logic [2:0] MIN_T,
  output logic [3:0] MIN_U,
  output logic [2:0] SEC_T,
  output logic [3:0] SEC_U,
  output logic       Running,
  output logic       Alarm,
  output logic [1:0] DBG_STATE
);

  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, PAUSE = 2'd2, RING = 2'd3} state_t;

  localparam logic [7:0] BEEP_LIM = 8'(BEEP_TICKS);

  state_t     state_q, state_d;
  logic [2:0] mt_q, mt_d, st_q, st_d;
  logic [3:0] mu_q, mu_d, su_q, su_d;
  logic [7:0] beep_q, beep_d;
  logic       running_q, alarm_q;

  logic [2:0] dec_mt, dec_st, ld_mt, ld_st;
  logic [3:0] dec_mu, dec_su, ld_mu, ld_su;
  logic       borrow_s, borrow_t, borrow_m;
  logic       count_zero, count_one;

  assign count_zero = (mt_q == 3'd0) && (mu_q == 4'd0) && (st_q == 3'd0) && (su_q == 4'd0);
  assign count_one  = (mt_q == 3'd0) && (mu_q == 4'd0) && (st_q == 3'd0) && (su_q == 4'd1);

  assign ld_mt = (IN_MT > 3'd5) ? 3'd5 : IN_MT;
  assign ld_mu = (IN_MU > 4'd9) ? 4'd9 : IN_MU;
  assign ld_st = (IN_ST > 3'd5) ? 3'd5 : IN_ST;
  assign ld_su = (IN_SU > 4'd9) ? 4'd9 : IN_SU;

  // One-second borrow chain: each digit moves only when the digit below wraps.
  always_comb begin
    borrow_s = (su_q == 4'd0);
    dec_su   = borrow_s ? 4'd9 : su_q - 4'd1;
    borrow_t = 1'b0;
    dec_st   = st_q;
    if (borrow_s) begin
      borrow_t = (st_q == 3'd0);
      dec_st   = borrow_t ? 3'd5 : st_q - 3'd1;
    end
    borrow_m = 1'b0;
    dec_mu   = mu_q;
    if (borrow_t) begin
      borrow_m = (mu_q == 4'd0);
      dec_mu   = borrow_m ? 4'd9 : mu_q - 4'd1;
    end
    dec_mt = borrow_m ? mt_q - 3'd1 : mt_q;
  end

  always_comb begin
    state_d = state_q;
    mt_d    = mt_q;
    mu_d    = mu_q;
    st_d    = st_q;
    su_d    = su_q;
    beep_d  = beep_q;
    if (Stop) begin
      case (state_q)
        RUN:         state_d = PAUSE;
        PAUSE, RING: state_d = IDLE;
        default:     state_d = state_q;
      endcase
    end
`ifdef COUNTDOWN_SNOOZE_EN
    else if (Snooze && (state_q == RING)) begin
      state_d = RUN;
      mt_d    = 3'd0;
      mu_d    = 4'(SNOOZE_MIN);
      st_d    = 3'd0;
      su_d    = 4'd0;
    end
`endif
    else if (LD && (state_q != RUN)) begin
      mt_d = ld_mt;
      mu_d = ld_mu;
      st_d = ld_st;
      su_d = ld_su;
      if (state_q == RING) state_d = IDLE;
    end else if (Start && ((state_q == IDLE) || (state_q == PAUSE)) && !count_zero) begin
      state_d = RUN;
    end else if (Tick) begin
      if (state_q == RUN) begin
        mt_d = dec_mt;
        mu_d = dec_mu;
        st_d = dec_st;
        su_d = dec_su;
        if (count_one) begin
          state_d = RING;
          beep_d  = 8'd0;
        end
      end else if (state_q == RING) begin
        beep_d = beep_q + 8'd1;
        if (beep_d == BEEP_LIM) begin
          state_d = IDLE;
          beep_d  = 8'd0;
        end
      end
    end
  end

  always_ff @(posedge Clk or negedge Clr) begin
    if (!Clr) begin
      state_q   <= IDLE;
      mt_q      <= 3'd0;
      mu_q      <= 4'd0;
      st_q      <= 3'd0;
      su_q      <= 4'd0;
      beep_q    <= 8'd0;
      running_q <= 1'b0;
      alarm_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      mt_q      <= mt_d;
      mu_q      <= mu_d;
      st_q      <= st_d;
      su_q      <= su_d;
      beep_q    <= beep_d;
      running_q <= (state_d == RUN);
      alarm_q   <= (state_d == RING);
    end
  end

  assign MIN_T     = mt_q;
  assign MIN_U     = mu_q;
  assign SEC_T     = st_q;
  assign SEC_U     = su_q;
  assign Running   = running_q;
  assign Alarm     = alarm_q;
  assign DBG_STATE = state_q;

endmodule

// File: tb/tb_countdown_mm_ss.sv
// Directed bench for countdown_mm_ss: loads, borrow chain, expiry/ring, pause/resume, event priority.
`timescale 1ns/1ps
module tb_countdown_mm_ss;

  localparam logic [1:0] S_IDLE = 2'd0, S_RUN = 2'd1, S_PAUSE = 2'd2, S_RING = 2'd3;

  logic       clk = 1'b0;
  logic       clr, tick, ld, start, stop;
  logic [2:0] in_mt, in_st;
  logic [3:0] in_mu, in_su;
  logic [2:0] min_t, sec_t;
  logic [3:0] min_u, sec_u;
  logic       running, alarm;
  logic [1:0] dbg_state;
`ifdef COUNTDOWN_SNOOZE_EN
  logic       snooze;
`endif

  int n_checks = 0;
  int n_fail   = 0;
  logic [17:0] e;

  countdown_mm_ss #(.BEEP_TICKS(10)) dut (
    .Clk(clk), .Clr(clr), .Tick(tick), .LD(ld),
    .IN_MT(in_mt), .IN_MU(in_mu), .IN_ST(in_st), .IN_SU(in_su),
    .Start(start), .Stop(stop),
`ifdef COUNTDOWN_SNOOZE_EN
    .Snooze(snooze),
`endif
    .MIN_T(min_t), .MIN_U(min_u), .SEC_T(sec_t), .SEC_U(sec_u),
    .Running(running), .Alarm(alarm), .DBG_STATE(dbg_state)
  );

  always #5 clk = ~clk;

  wire [17:0] status = {min_t, min_u, sec_t, sec_u, running, alarm, dbg_state};

  // Expected status: digits plus the flags each state implies.
  function automatic logic [17:0] exp_st(int mt, int mu, int st, int su, logic [1:0] s);
    return {3'(mt), 4'(mu), 3'(st), 4'(su), s == S_RUN, s == S_RING, s};
  endfunction

  function automatic string fmt(logic [17:0] v);
    return $sformatf("%0d%0d:%0d%0d run=%0b alarm=%0b state=%0d",
                     v[17:15], v[14:11], v[10:8], v[7:4], v[3], v[2], v[1:0]);
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_load(int mt, int mu, int st, int su);
    ld = 1'b1; in_mt = 3'(mt); in_mu = 4'(mu); in_st = 3'(st); in_su = 4'(su);
    step();
    ld = 1'b0;
  endtask

  task automatic do_start();
    start = 1'b1; step(); start = 1'b0;
  endtask

  task automatic do_stop();
    stop = 1'b1; step(); stop = 1'b0;
  endtask

  task automatic do_tick();
    tick = 1'b1; step(); tick = 1'b0;
  endtask

  task automatic test_reset();
    clr = 1'b0;
    step();
    e = exp_st(0, 0, 0, 0, S_IDLE); n_checks++;
    if (status !== e) begin n_fail++; $display("FAIL reset_initial: got %s expected %s", fmt(status), fmt(e)); end
    #2 clr = 1'b1;
    do_load(0, 3, 2, 7);
    do_start();
    e = exp_st(0, 3, 2, 7, S_RUN); n_checks++;
    if (status !== e) begin n_fail++; $display("FAIL reset_prerun: got %s expected %s", fmt(status), fmt(e)); end
    #3 clr = 1'b0;
    #1;
    e = exp_st(0, 0, 0, 0, S_IDLE); n_checks++;
    if (status !== e) begin n_fail++; $display("FAIL reset_async: got %s expected %s", fmt(status), fmt(e)); end
    #2 clr = 1'b1;
    do_tick();
    step();
    e = exp_st(0, 0, 0, 0, S_IDLE); n_checks++;
    if (status !== e) begin n_fail++; $display("FAIL reset_release: got %s expected %s", fmt(status), fmt(e)); end
    do_start();
    e = exp_st(0, 0, 0, 0, S_IDLE); n_checks++;
    if (status !== e) begin n_fail++; $display("FAIL start_at_zero: got %s expected %s", fmt(status), fmt(e)); end
  endtask

  task automatic test_load_borrow();
    do_load(1, 0, 0, 0);
    e = exp_st(1, 0, 0, 0, S_IDLE); n_checks++;
    if (status !== e) begin n_fail++; $display("FAIL load_10_00: got %s expected %s", fmt(status), fmt(e)); end
    do_start();
    do_tick();
    e = exp_st(0, 9, 5, 9, S_RUN); n_checks++;
    if (status !== e) begin n_fail++; $display("FAIL borrow_chain: got %s expected %s", fmt(status), fmt(e)); end
    do_load(2, 2, 2, 2);
    e = exp_st(0, 9, 5, 9, S_RUN); n_checks++;
    if (status !== e) begin n_fail++; $display("FAIL load_in_run: got %s expected %s", fmt(status), fmt(e)); end
    do_stop();
    do_stop();
    e = exp_st(0, 9, 5, 9, S_IDLE); n_checks++;
    if (status !== e) begin n_fail++; $display("FAIL stop_twice: got %s expected %s", fmt(status), fmt(e)); end
    do_load(0, 0, 6, 15);
    e = exp_st(0, 0, 5, 9, S_IDLE); n_checks++;
    if (status !== e) begin n_fail++; $display("FAIL clamp_secs: got %s expected %s", fmt(status), fmt(e)); end
    do_load(7, 12, 3, 4);
    do_tick();
    e = exp_st(5, 9, 3, 4, S_IDLE); n_checks++;
    if (status !== e) begin n_fail++; $display("FAIL clamp_mins_idle_tick: got %s expected %s", fmt(status), fmt(e)); end
  endtask

  task automatic test_expiry();
    do_load(0, 0, 0, 2);
    do_start();
    do_tick();
    e = exp_st(0, 0, 0, 1, S_RUN); n_checks++;
    if (status !== e) begin n_fail++; $display("FAIL expiry_0001: got %s expected %s", fmt(status), fmt(e)); end
    do_tick();
    e = exp_st(0, 0, 0, 0, S_RING); n_checks++;
    if (status !== e) begin n_fail++; $display("FAIL expiry_ring: got %s expected %s", fmt(status), fmt(e)); end
    do_start();
    for (int i = 0; i < 9; i++) do_tick();
    e = exp_st(0, 0, 0, 0, S_RING); n_checks++;
    if (status !== e) begin n_fail++; $display("FAIL ring_9_ticks: got %s expected %s", fmt(status), fmt(e)); end
    do_tick();
    e = exp_st(0, 0, 0, 0, S_IDLE); n_checks++;
    if (status !== e) begin n_fail++; $display("FAIL ring_expire: got %s expected %s", fmt(status), fmt(e)); end
    for (int i = 0; i < 3; i++) do_tick();
    e = exp_st(0, 0, 0, 0, S_IDLE); n_checks++;
    if (status !== e) begin n_fail++; $display("FAIL idle_extra_ticks: got %s expected %s", fmt(status), fmt(e)); end
    do_load(0, 0, 0, 1);
    do_start();
    do_tick();
    for (int i = 0; i < 4; i++) do_tick();
    do_stop();
    e = exp_st(0, 0, 0, 0, S_IDLE); n_checks++;
    if (status !== e) begin n_fail++; $display("FAIL stop_in_ring: got %s expected %s", fmt(status), fmt(e)); end
    do_load(0, 0, 0, 1);
    do_start();
    do_tick();
    for (int i = 0; i < 9; i++) do_tick();
    e = exp_st(0, 0, 0, 0, S_RING); n_checks++;
    if (status !== e) begin n_fail++; $display("FAIL beep_cleared: got %s expected %s", fmt(status), fmt(e)); end
    do_load(4, 0, 0, 0);
    e = exp_st(4, 0, 0, 0, S_IDLE); n_checks++;
    if (status !== e) begin n_fail++; $display("FAIL load_in_ring: got %s expected %s", fmt(status), fmt(e)); end
  endtask

  task automatic test_pause_resume();
    do_load(0, 1, 0, 0);
    do_start();
    for (int i = 0; i < 3; i++) do_tick();
    e = exp_st(0, 0, 5, 7, S_RUN); n_checks++;
    if (status !== e) begin n_fail++; $display("FAIL run_3_ticks: got %s expected %s", fmt(status), fmt(e)); end
    do_stop();
    for (int i = 0; i < 5; i++) do_tick();
    e = exp_st(0, 0, 5, 7, S_PAUSE); n_checks++;
    if (status !== e) begin n_fail++; $display("FAIL pause_hold: got %s expected %s", fmt(status), fmt(e)); end
    do_start();
    do_tick();
    e = exp_st(0, 0, 5, 6, S_RUN); n_checks++;
    if (status !== e) begin n_fail++; $display("FAIL resume_tick: got %s expected %s", fmt(status), fmt(e)); end
    do_stop();
    start = 1'b1; stop = 1'b1;
    step();
    start = 1'b0; stop = 1'b0;
    e = exp_st(0, 0, 5, 6, S_IDLE); n_checks++;
    if (status !== e) begin n_fail++; $display("FAIL start_stop_pause: got %s expected %s", fmt(status), fmt(e)); end
    do_stop();
    e = exp_st(0, 0, 5, 6, S_IDLE); n_checks++;
    if (status !== e) begin n_fail++; $display("FAIL stop_in_idle: got %s expected %s", fmt(status), fmt(e)); end
  endtask

  task automatic test_simultaneous();
    ld = 1'b1; start = 1'b1; in_mt = 3'd0; in_mu = 4'd0; in_st = 3'd0; in_su = 4'd5;
    step();
    ld = 1'b0; start = 1'b0;
    e = exp_st(0, 0, 0, 5, S_IDLE); n_checks++;
    if (status !== e) begin n_fail++; $display("FAIL ld_start_idle: got %s expected %s", fmt(status), fmt(e)); end
    do_start();
    tick = 1'b1; stop = 1'b1;
    step();
    tick = 1'b0; stop = 1'b0;
    e = exp_st(0, 0, 0, 5, S_PAUSE); n_checks++;
    if (status !== e) begin n_fail++; $display("FAIL tick_stop_run: got %s expected %s", fmt(status), fmt(e)); end
    do_load(0, 1, 0, 0);
    e = exp_st(0, 1, 0, 0, S_PAUSE); n_checks++;
    if (status !== e) begin n_fail++; $display("FAIL load_in_pause: got %s expected %s", fmt(status), fmt(e)); end
    ld = 1'b1; stop = 1'b1; in_mt = 3'd3; in_mu = 4'd3; in_st = 3'd3; in_su = 4'd3;
    step();
    ld = 1'b0; stop = 1'b0;
    e = exp_st(0, 1, 0, 0, S_IDLE); n_checks++;
    if (status !== e) begin n_fail++; $display("FAIL stop_over_ld: got %s expected %s", fmt(status), fmt(e)); end
  endtask

`ifdef COUNTDOWN_SNOOZE_EN
  task automatic test_snooze();
    do_load(0, 0, 0, 1);
    do_start();
    do_tick();
    snooze = 1'b1; step(); snooze = 1'b0;
    e = exp_st(0, 5, 0, 0, S_RUN); n_checks++;
    if (status !== e) begin n_fail++; $display("FAIL snooze_reload: got %s expected %s", fmt(status), fmt(e)); end
    do_tick();
    e = exp_st(0, 4, 5, 9, S_RUN); n_checks++;
    if (status !== e) begin n_fail++; $display("FAIL snooze_tick: got %s expected %s", fmt(status), fmt(e)); end
    snooze = 1'b1; step(); snooze = 1'b0;
    e = exp_st(0, 4, 5, 9, S_RUN); n_checks++;
    if (status !== e) begin n_fail++; $display("FAIL snooze_in_run: got %s expected %s", fmt(status), fmt(e)); end
  endtask
`endif

  initial begin
    clr = 1'b0; tick = 1'b0; ld = 1'b0; start = 1'b0; stop = 1'b0;
    in_mt = 3'd0; in_mu = 4'd0; in_st = 3'd0; in_su = 4'd0;
`ifdef COUNTDOWN_SNOOZE_EN
    snooze = 1'b0;
`endif
    test_reset();
    test_load_borrow();
    test_expiry();
    test_pause_resume();
    test_simultaneous();
`ifdef COUNTDOWN_SNOOZE_EN
    test_snooze();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
